// File: rtl/button_debounce.sv
// Per-channel push-button conditioner: 2-flop synchroniser, debounce FSM and
// hold counter. Produces a clean pressed level plus registered single-cycle
// press, release and long-press pulses for fabric logic.
module button_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               FAB_CLK,
    input  logic               FAB_RESET,
    input  logic [NUM_BTN-1:0] BTN_IN,
    output logic [NUM_BTN-1:0] BTN_STATE,
    output logic [NUM_BTN-1:0] BTN_PRESS,
    output logic [NUM_BTN-1:0] BTN_RELEASE,
    output logic [NUM_BTN-1:0] BTN_LONG,
    output logic [NUM_BTN-1:0] BTN_LONG_STATE
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
    // Pad level when nobody touches the button; the synchroniser resets here
    // so that leaving reset never looks like a press.
    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            sync1 <= {NUM_BTN{INACTIVE}};
            sync2 <= {NUM_BTN{INACTIVE}};
        end else begin
            sync1 <= BTN_IN;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        state_t        state, state_next;
        logic [DW-1:0] dcnt, dcnt_next;
        logic [LW-1:0] lcnt, lcnt_next;
        logic          level, level_next;
        logic          long_state, long_state_next;
        logic          press, press_next;
        logic          release_evt, release_next;
        logic          long_evt, long_next;
        logic          norm;

        // Normalised pad: 1 means the button is physically pressed.
        assign norm = (ACTIVE_LOW != 0) ? ~sync2[i] : sync2[i];

        // State, counters and all outputs are registered here.
        always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
            if (FAB_RESET) begin
                state       <= IDLE;
                dcnt        <= '0;
                lcnt        <= '0;
                level       <= 1'b0;
                long_state  <= 1'b0;
                press       <= 1'b0;
                release_evt <= 1'b0;
                long_evt    <= 1'b0;
            end else begin
                state       <= state_next;
                dcnt        <= dcnt_next;
                lcnt        <= lcnt_next;
                level       <= level_next;
                long_state  <= long_state_next;
                press       <= press_next;
                release_evt <= release_next;
                long_evt    <= long_next;
            end
        end

        // Debounce and hold-time decisions; pulses default low every cycle.
        always_comb begin
            state_next      = state;
            dcnt_next       = dcnt;
            lcnt_next       = lcnt;
            level_next      = level;
            long_state_next = long_state;
            press_next      = 1'b0;
            release_next    = 1'b0;
            long_next       = 1'b0;
            case (state)
                IDLE: begin
                    if (norm) begin
                        state_next = PRESS_WAIT;
                        dcnt_next  = DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!norm) begin
                        state_next = IDLE;
                    end else if (dcnt == D_LAST) begin
                        state_next = PRESSED;
                        level_next = 1'b1;
                        press_next = 1'b1;
                        lcnt_next  = '0;
                    end else begin
                        dcnt_next = dcnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!norm) begin
                        // Hold count stays frozen while the release is in doubt.
                        state_next = RELEASE_WAIT;
                        dcnt_next  = DW'(1);
                    end else if (!long_state) begin
                        if (lcnt == L_LAST) begin
                            long_next       = 1'b1;
                            long_state_next = 1'b1;
                        end else begin
                            lcnt_next = lcnt + LW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (norm) begin
                        state_next = PRESSED;
                    end else if (dcnt == D_LAST) begin
                        state_next      = IDLE;
                        level_next      = 1'b0;
                        release_next    = 1'b1;
                        long_state_next = 1'b0;
                        lcnt_next       = '0;
                    end else begin
                        dcnt_next = dcnt + DW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        assign BTN_STATE[i]      = level;
        assign BTN_PRESS[i]      = press;
        assign BTN_RELEASE[i]    = release_evt;
        assign BTN_LONG[i]       = long_evt;
        assign BTN_LONG_STATE[i] = long_state;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: run-length reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized pad activity.
module tb_button_debounce;

    localparam int NB = 4;
    localparam int D  = 8;
    localparam int L  = 32;
    localparam int AL = 1;

    logic          FAB_CLK   = 1'b0;
    logic          FAB_RESET = 1'b1;
    logic [NB-1:0] BTN_IN    = '1;
    logic [NB-1:0] BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_LONG_STATE;

    button_debounce #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(AL)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .FAB_RESET(FAB_RESET),
        .BTN_IN(BTN_IN),
        .BTN_STATE(BTN_STATE),
        .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE),
        .BTN_LONG(BTN_LONG),
        .BTN_LONG_STATE(BTN_LONG_STATE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit armed  = 1'b0;
    int press_cnt [NB];
    int rel_cnt   [NB];
    int long_cnt  [NB];

    // Reference model: a level is accepted once the synchronised sample has
    // disagreed with the accepted level for D consecutive edges; the hold
    // count advances only on edges where the button is settled-pressed.
    logic [NB-1:0] hist0 = '0, hist1 = '0;
    logic [NB-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0, m_lst = '0;
    int            m_run  [NB];
    int            m_hold [NB];

    initial begin
        for (int c = 0; c < NB; c++) begin
            m_run[c] = 0; m_hold[c] = 0;
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
        end
    end

    initial forever begin
        @(posedge FAB_CLK or posedge FAB_RESET);
        if (FAB_RESET) begin
            hist0 = '0; hist1 = '0;
            m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_lst = '0;
            for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_hold[c] = 0; end
        end else begin
            m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < NB; c++) begin
                if (hist1[c] != m_state[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_run[c]   = 0;
                        m_hold[c]  = 0;
                        m_state[c] = hist1[c];
                        if (hist1[c]) m_press[c] = 1'b1;
                        else begin m_rel[c] = 1'b1; m_lst[c] = 1'b0; end
                    end
                end else begin
                    if (m_state[c] && m_run[c] == 0 && !m_lst[c]) begin
                        m_hold[c]++;
                        if (m_hold[c] == L) begin m_long[c] = 1'b1; m_lst[c] = 1'b1; end
                    end
                    m_run[c] = 0;
                end
            end
            hist1 = hist0;
            hist0 = (AL != 0) ? ~BTN_IN : BTN_IN;
        end
    end

    initial forever begin
        @(posedge FAB_CLK);
        cyc++;
    end

    task automatic cmp(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // Every-cycle comparison against the model, plus pulse tallies.
    initial forever begin
        @(negedge FAB_CLK);
        if (armed) begin
            cmp("state", BTN_STATE, m_state);
            cmp("press", BTN_PRESS, m_press);
            cmp("release", BTN_RELEASE, m_rel);
            cmp("long", BTN_LONG, m_long);
            cmp("long_state", BTN_LONG_STATE, m_lst);
            for (int c = 0; c < NB; c++) begin
                press_cnt[c] += int'(BTN_PRESS[c]);
                rel_cnt[c]   += int'(BTN_RELEASE[c]);
                long_cnt[c]  += int'(BTN_LONG[c]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge FAB_CLK);
    endtask

    // Wait until edge k after 'base' (edge 0 is the first edge after base).
    task automatic run_to(input int base, input int k);
        while (cyc - base - 1 < k) @(negedge FAB_CLK);
    endtask

    // sel: 0 press, 1 release, 2 long on channel ch; 3 any press, 4 any release.
    task automatic wait_evt(input int sel, input int ch, input int limit, output int at);
        int  n;
        bit  hit;
        n = 0; hit = 1'b0; at = -1;
        while (!hit && n < limit) begin
            @(negedge FAB_CLK);
            n++;
            case (sel)
                0:       hit = BTN_PRESS[ch];
                1:       hit = BTN_RELEASE[ch];
                2:       hit = BTN_LONG[ch];
                3:       hit = (BTN_PRESS != '0);
                default: hit = (BTN_RELEASE != '0);
            endcase
        end
        if (hit) at = cyc;
        else begin
            errors++; checks++;
            $display("FAIL wait_evt sel=%0d ch=%0d: got timeout expected event within %0d cycles", sel, ch, limit);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        cmp({nm, "_state"}, BTN_STATE, '0);
        cmp({nm, "_press"}, BTN_PRESS, '0);
        cmp({nm, "_rel"}, BTN_RELEASE, '0);
        cmp({nm, "_long"}, BTN_LONG, '0);
        cmp({nm, "_lst"}, BTN_LONG_STATE, '0);
    endtask

    function automatic int total_events();
        int t = 0;
        for (int c = 0; c < NB; c++) t += press_cnt[c] + rel_cnt[c] + long_cnt[c];
        return t;
    endfunction

    initial begin
        int base, at, pat, lat, p0, l0, ev0;

        // Reset state, then idle pads produce nothing.
        tick(3);
        armed = 1'b1;
        chk_all_zero("reset");
        FAB_RESET = 1'b0;
        tick(20);
        #2;
        chk("idle_no_events", total_events(), 0);

        // Clean press and release on channel 0.
        @(negedge FAB_CLK);
        base = cyc; BTN_IN[0] = 1'b0;
        wait_evt(0, 0, 40, at);
        chk("press_latency0", at - base - 1, 9);
        chk("state0_pressed", int'(BTN_STATE[0]), 1);
        run_to(base, 19);
        base = cyc; BTN_IN[0] = 1'b1;
        wait_evt(1, 0, 40, at);
        chk("release_latency0", at - base - 1, 9);
        chk("state0_released", int'(BTN_STATE[0]), 0);

        // Short low glitch on channel 1 is rejected.
        tick(3);
        #2;
        p0 = press_cnt[1];
        @(negedge FAB_CLK);
        BTN_IN[1] = 1'b0; tick(5); BTN_IN[1] = 1'b1; tick(20);
        #2;
        chk("glitch_no_press1", press_cnt[1] - p0, 0);
        chk("glitch_state1", int'(BTN_STATE[1]), 0);

        // Short high glitch while pressed is rejected.
        @(negedge FAB_CLK);
        BTN_IN[1] = 1'b0;
        wait_evt(0, 1, 40, at);
        tick(3);
        #2;
        p0 = rel_cnt[1];
        @(negedge FAB_CLK);
        BTN_IN[1] = 1'b1; tick(5); BTN_IN[1] = 1'b0; tick(20);
        #2;
        chk("glitch_no_release1", rel_cnt[1] - p0, 0);
        chk("glitch_state1_held", int'(BTN_STATE[1]), 1);
        @(negedge FAB_CLK);
        BTN_IN[1] = 1'b1;
        wait_evt(1, 1, 40, at);

        // Long press on channel 2.
        tick(3);
        #2;
        l0 = long_cnt[2];
        @(negedge FAB_CLK);
        base = cyc; BTN_IN[2] = 1'b0;
        wait_evt(0, 2, 40, pat);
        wait_evt(2, 2, 60, lat);
        chk("long_after_press2", lat - pat, 32);
        chk("long_state2_set", int'(BTN_LONG_STATE[2]), 1);
        run_to(base, 59);
        BTN_IN[2] = 1'b1;
        wait_evt(1, 2, 40, at);
        chk("long_state2_cleared", int'(BTN_LONG_STATE[2]), 0);
        #2;
        chk("long_once2", long_cnt[2] - l0, 1);

        // A 20-cycle press gives no long event.
        l0 = long_cnt[2];
        @(negedge FAB_CLK);
        BTN_IN[2] = 1'b0; tick(20); BTN_IN[2] = 1'b1; tick(15);
        #2;
        chk("short_no_long2", long_cnt[2] - l0, 0);

        // All channels pressed and released together.
        @(negedge FAB_CLK);
        BTN_IN = '0;
        wait_evt(3, 0, 30, at);
        cmp("simul_press", BTN_PRESS, 4'hF);
        tick(10);
        BTN_IN = '1;
        wait_evt(4, 0, 30, at);
        cmp("simul_release", BTN_RELEASE, 4'hF);
        tick(5);

        // Reset mid-press on channel 3, released with the pad still held.
        BTN_IN[3] = 1'b0;
        wait_evt(0, 3, 40, at);
        tick(4);
        #2;
        FAB_RESET = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick(3);
        FAB_RESET = 1'b0;
        base = cyc;
        wait_evt(0, 3, 40, at);
        chk("repress_latency3", at - base - 1, 9);

        // Reset released with all pads idle produces nothing.
        BTN_IN = '1;
        tick(20);
        #2;
        FAB_RESET = 1'b1;
        tick(3);
        FAB_RESET = 1'b0;
        #2;
        ev0 = total_events();
        tick(30);
        #2;
        chk("idle_reset_no_events", total_events() - ev0, 0);

        // Hold counter freezes across a release glitch on channel 0.
        @(negedge FAB_CLK);
        base = cyc; BTN_IN[0] = 1'b0;
        wait_evt(0, 0, 40, pat);
        chk("frozen_press0", pat - base - 1, 9);
        run_to(base, 19);
        BTN_IN[0] = 1'b1;
        run_to(base, 24);
        BTN_IN[0] = 1'b0;
        wait_evt(2, 0, 60, lat);
        chk("frozen_long_edge0", lat - base - 1, 47);
        chk("frozen_long_after_press0", lat - pat, 38);
        BTN_IN[0] = 1'b1;
        wait_evt(1, 0, 40, at);
        tick(5);

        // Randomized pad activity with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge FAB_CLK);
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 24) == 0) BTN_IN[c] = ~BTN_IN[c];
            if (i == 1500) begin
                #2;
                FAB_RESET = 1'b1;
                tick(2);
                FAB_RESET = 1'b0;
            end
        end
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the fabric LED driver. Samples NUM_BTN board push-buttons on FAB_CLK, synchronises and debounces each one, and reports clean levels plus single-cycle press, release and long-press events to fabric logic, e.g. an LED pattern selector.
- Each button has its own independent synchroniser, debounce FSM and hold counter.

Parameters:
- NUM_BTN, 4: number of button channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a level change (10 ms at 50 MHz). Must be >= 2.
- LONG_CYCLES, 50000000: accepted-pressed cycles before a long-press event (1 s at 50 MHz). Must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 means the pad reads 0 when pressed; 0 means the pad reads 1 when pressed.

Ports:
- FAB_CLK  input  1  single fabric clock; all logic on its rising edge.
- FAB_RESET  input  1  asynchronous, active-high reset.
- BTN_IN  input  NUM_BTN  raw asynchronous button pads.
- BTN_STATE  output  NUM_BTN  debounced level; 1 = pressed.
- BTN_PRESS  output  NUM_BTN  1-cycle pulse on accepted press.
- BTN_RELEASE  output  NUM_BTN  1-cycle pulse on accepted release.
- BTN_LONG  output  NUM_BTN  1-cycle pulse when a press reaches LONG_CYCLES.
- BTN_LONG_STATE  output  NUM_BTN  1 from the BTN_LONG pulse until the accepted release.

Behaviour:
- Reset (asynchronous, FAB_RESET=1):
  - All outputs 0, all counters 0, all FSMs IDLE.
  - Both synchroniser flops reset to the inactive pad level (1 if ACTIVE_LOW, else 0), so release of reset never produces a spurious press.
  - Reset asserted mid-press clears everything immediately. A button still held when reset is released is re-debounced from IDLE and produces a fresh BTN_PRESS.
- Synchroniser: 2-flop per bit. norm = ACTIVE_LOW ? ~sync2 : sync2.
- FSM per channel, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; debounce counter dcnt:
  - IDLE: norm=1 -> PRESS_WAIT, dcnt<=1.
  - PRESS_WAIT:
    - norm=0 -> IDLE, no event (glitch rejected).
    - norm=1 and dcnt==DEBOUNCE_CYCLES-1 -> PRESSED; BTN_STATE<=1; BTN_PRESS=1 for that one cycle; hold counter lcnt<=0.
    - Otherwise dcnt++.
  - PRESSED:
    - norm=0 -> RELEASE_WAIT, dcnt<=1, lcnt frozen.
    - Otherwise, if BTN_LONG_STATE=0, lcnt++. When lcnt==LONG_CYCLES-1: BTN_LONG pulses 1 cycle, BTN_LONG_STATE<=1, and lcnt stops.
  - RELEASE_WAIT:
    - norm=1 -> PRESSED, no event; lcnt resumes from its frozen value.
    - norm=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE; BTN_STATE<=0; BTN_RELEASE pulse; BTN_LONG_STATE<=0; lcnt<=0.
    - Otherwise dcnt++.
- Latency: pad changes before edge 0. BTN_STATE and BTN_PRESS update on edge DEBOUNCE_CYCLES+1. Release latency is the same.
- Output timing:
  - All outputs are registered.
  - BTN_PRESS and BTN_RELEASE pulse on the same edge as the BTN_STATE change.
  - BTN_LONG and BTN_LONG_STATE rise on the same edge.
- BTN_LONG fires at most once per accepted press. A press released before LONG_CYCLES gives no long event.
- Channels are fully independent. Pulses on several channels in the same cycle are legal and all appear.
- Counter widths: ceil(log2(DEBOUNCE_CYCLES+1)) and ceil(log2(LONG_CYCLES+1)). Counters never wrap; they saturate by construction at their terminal compare.

Test Plan (NUM_BTN=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1):
- Clean press, then release, of BTN_IN[0]:
  - Drive BTN_IN[0] 1->0 before edge 0, hold 20 cycles -> BTN_STATE[0]=1 and BTN_PRESS[0] pulses exactly on edge 9.
  - Drive back to 1 -> BTN_RELEASE[0] pulses 9 edges later, BTN_STATE[0]=0.
- Glitch rejection:
  - BTN_IN[1] low for 5 cycles, then high -> no PRESS, STATE stays 0.
  - While pressed, a 5-cycle high glitch -> no RELEASE, STATE stays 1.
- Long press: hold BTN_IN[2] low for 60 cycles:
  - BTN_LONG[2] pulses once, 32 edges after BTN_PRESS[2].
  - BTN_LONG_STATE[2]=1 until the accepted release, then 0.
  - A 20-cycle press gives no BTN_LONG.
- Simultaneous: all four pads low on the same cycle -> BTN_PRESS=4'hF pulsed on one edge; all released together -> BTN_RELEASE=4'hF on one edge.
- Reset:
  - Assert FAB_RESET mid-press on channel 3 -> all outputs 0 immediately.
  - Deassert with pad still low -> fresh BTN_PRESS[3] 9 edges after the first post-reset sample.
  - With all pads high at reset release -> no events.
- Frozen hold counter: press channel 0 for 20 cycles, 5-cycle high glitch, keep pressed -> BTN_LONG[0] fires 32 PRESSED-counted cycles after PRESS. The glitch cycles are not counted.
